// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store: grant, issue, wait MEM_LAT, respond.
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              own_d;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  state_t            state;
  acc_t              acc;
  logic [CNT_W-1:0]  cnt;
  logic              mem_en_q, busy_q, if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              arb_win, sel_d, sel_f, force_f;

  // Illegal parameterisations simply elaborate this empty marker block.
  if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
  end

  // Grants are gated by reset so every output reads 0 while rst_n is low.
  assign arb_win = rst_n && (state == IDLE || state == RESP);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  logic [SC_W-1:0] starve_cnt;

  assign force_f = bus.if_req && (starve_cnt >= SC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (arb_win) begin
      if (!bus.if_req || sel_f)
        starve_cnt <= '0;
      else if (sel_d && starve_cnt != SC_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_f = 1'b0;
`endif

  assign sel_d = arb_win && bus.d_req && !force_f;
  assign sel_f = arb_win && bus.if_req && !sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      mem_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (sel_d || sel_f) begin
            acc.own_d <= sel_d;
            acc.we    <= sel_d & bus.d_we;
            acc.addr  <= sel_d ? bus.d_addr : bus.if_addr;
            acc.wdata <= sel_d ? bus.d_wdata : '0;
            mem_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            state     <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            // Stores capture too; the value is simply never consumed.
            if (acc.own_d) d_rdata_q  <= bus.mem_rdata;
            else           if_rdata_q <= bus.mem_rdata;
            d_rvalid_q  <= acc.own_d;
            if_rvalid_q <= !acc.own_d;
            busy_q      <= 1'b0;
            state       <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = sel_f;
  assign bus.d_gnt     = sel_d;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = acc.we;
  assign bus.mem_addr  = acc.addr;
  assign bus.mem_wdata = acc.wdata;
  assign bus.busy      = busy_q;

endmodule
